seq_pattern_detector: RTL and testbench

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

---
 rtl/seq_pattern_detector.sv | 86 ++++++++
 tb/tb_seq_pattern_detector.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - sliding-window symbol pattern detector with match pulse, toggle and counter
// Optional saturating match counter is built only when SEQ_DET_COUNT_EN is defined.
module seq_pattern_detector #(
  parameter int W                     = 2,
  parameter int LEN                   = 4,
  parameter int CW                    = 8,
  parameter int OVERLAP               = 1,
  parameter logic [W*LEN-1:0] PAT_INIT = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sym_vld,
  input  logic [W-1:0]      sym,
  input  logic              pat_load,
  input  logic [W*LEN-1:0]  pat_data,
  output logic              y,
  output logic              z,
  output logic              t,
  output logic [CW-1:0]     match_cnt
);

  localparam int FW = $clog2(LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(LEN);

  logic [W*LEN-1:0] pat;
  logic [W*LEN-1:0] hist;
  logic [W*LEN-1:0] hist_nx;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_inc;
  logic [FW-1:0]    fill_nx;
  logic             hit;

  always_comb begin
    hist_nx  = {hist[W*(LEN-1)-1:0], sym};
    fill_inc = (fill == FULL) ? fill : fill + 1'b1;
    hit      = 1'b0;
    fill_nx  = fill;
    if (pat_load) begin
      fill_nx = '0;
    end else if (sym_vld) begin
      hit     = (fill_inc == FULL) && (hist_nx == pat);
      // Non-overlapping mode restarts the window after each match.
      fill_nx = (hit && (OVERLAP == 0)) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pat  <= PAT_INIT;
      hist <= '0;
      fill <= '0;
      y    <= 1'b0;
      z    <= 1'b0;
      t    <= 1'b0;
    end else begin
      if (pat_load) begin
        pat <= pat_data;
      end else if (sym_vld) begin
        hist <= hist_nx;
      end
      fill <= fill_nx;
      z    <= (fill_nx == FULL);
      y    <= hit;
      if (hit) begin
        t <= ~t;
      end
    end
  end

`ifdef SEQ_DET_COUNT_EN
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (hit && (cnt != {CW{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - scoreboard bench for seq_pattern_detector (overlap, non-overlap, CW=2)
module tb_seq_pattern_detector;

  typedef struct {
    logic t;
    int   cnt;
    logic z;
  } exp_t;

  localparam logic [2:0] ZAFT = 3'b101;

  logic       clock = 1'b0;
  logic       reset;
  logic       sym_vld;
  logic [1:0] sym;
  logic       pat_load;
  logic [7:0] pat_data;
  logic [2:0] yv, zv, tv;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  exp_t       sbq[3][$];
  exp_t       mon_e;
  logic [2:0] et;
  int         ecnt[3];
  int         nchecks = 0;
  int         nerrors = 0;

  always #5 clock = ~clock;

  seq_pattern_detector #(.W(2), .LEN(4), .CW(8), .OVERLAP(1)) u0 (
    .clock(clock), .reset(reset), .sym_vld(sym_vld), .sym(sym), .pat_load(pat_load),
    .pat_data(pat_data), .y(yv[0]), .z(zv[0]), .t(tv[0]), .match_cnt(c0));
  seq_pattern_detector #(.W(2), .LEN(4), .CW(8), .OVERLAP(0)) u1 (
    .clock(clock), .reset(reset), .sym_vld(sym_vld), .sym(sym), .pat_load(pat_load),
    .pat_data(pat_data), .y(yv[1]), .z(zv[1]), .t(tv[1]), .match_cnt(c1));
  seq_pattern_detector #(.W(2), .LEN(4), .CW(2), .OVERLAP(1)) u2 (
    .clock(clock), .reset(reset), .sym_vld(sym_vld), .sym(sym), .pat_load(pat_load),
    .pat_data(pat_data), .y(yv[2]), .z(zv[2]), .t(tv[2]), .match_cnt(c2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0:       return {24'd0, c0};
      1:       return {24'd0, c1};
      default: return {30'd0, c2};
    endcase
  endfunction

  function automatic int cmax(input int i);
    return (i == 2) ? 3 : 255;
  endfunction

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (yv[i] === 1'b1) begin
        if (sbq[i].size() == 0) begin
          chk($sformatf("u%0d unexpected y", i), 32'd1, 32'd0);
        end else begin
          mon_e = sbq[i].pop_front();
          chk($sformatf("u%0d t at match", i), {31'd0, tv[i]}, {31'd0, mon_e.t});
          chk($sformatf("u%0d match_cnt at match", i), cnt_of(i), mon_e.cnt);
          chk($sformatf("u%0d z at match", i), {31'd0, zv[i]}, {31'd0, mon_e.z});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; sym_vld = 1'b0; pat_load = 1'b0;
    tick();
    reset = 1'b1;
    et = '0;
    for (int i = 0; i < 3; i++) ecnt[i] = 0;
  endtask

  task automatic load(input logic [7:0] p, input logic with_sym, input logic [1:0] s);
    pat_load = 1'b1; pat_data = p; sym_vld = with_sym; sym = s;
    tick();
    pat_load = 1'b0; sym_vld = 1'b0;
  endtask

  task automatic send(input logic [1:0] s, input logic [2:0] m);
    for (int i = 0; i < 3; i++) begin
      if (m[i]) begin
        et[i] = ~et[i];
`ifdef SEQ_DET_COUNT_EN
        if (ecnt[i] < cmax(i)) ecnt[i]++;
`endif
        sbq[i].push_back('{et[i], ecnt[i], ZAFT[i]});
      end
    end
    sym_vld = 1'b1; sym = s;
    tick();
    sym_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic endchk(input string tag, input logic [2:0] ez);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s u%0d pending y", tag, i), sbq[i].size(), 32'd0);
      chk($sformatf("%s u%0d z", tag, i), {31'd0, zv[i]}, {31'd0, ez[i]});
      chk($sformatf("%s u%0d t", tag, i), {31'd0, tv[i]}, {31'd0, et[i]});
      chk($sformatf("%s u%0d match_cnt", tag, i), cnt_of(i), ecnt[i]);
    end
  endtask

  initial begin
    reset = 1'b0; sym_vld = 1'b0; pat_load = 1'b0; sym = 2'd0; pat_data = 8'd0;
    et = '0;
    for (int i = 0; i < 3; i++) ecnt[i] = 0;
    tick();
    tick();
    reset = 1'b1;
    endchk("reset", 3'b000);

    load(8'h78, 1'b0, 2'd0);
    send(2'd1, 3'b000); send(2'd3, 3'b000); send(2'd2, 3'b000); send(2'd0, 3'b111);
    endchk("basic", 3'b101);

    do_reset();
    load(8'h55, 1'b0, 2'd0);
    repeat (3) send(2'd1, 3'b000);
    send(2'd1, 3'b111);
    repeat (3) send(2'd1, 3'b101);
    endchk("overlap", 3'b101);

    do_reset();
    load(8'h78, 1'b0, 2'd0);
    send(2'd1, 3'b000); idle(3);
    send(2'd3, 3'b000); idle(3);
    send(2'd2, 3'b000); idle(3);
    send(2'd0, 3'b111);
    endchk("gaps", 3'b101);

    do_reset();
    load(8'h78, 1'b0, 2'd0);
    send(2'd1, 3'b000); send(2'd3, 3'b000); send(2'd2, 3'b000);
    do_reset();
    send(2'd0, 3'b000);
    endchk("reset_mid", 3'b000);

    do_reset();
    load(8'h78, 1'b0, 2'd0);
    send(2'd1, 3'b000); send(2'd3, 3'b000); send(2'd2, 3'b000); send(2'd1, 3'b000);
    chk("collide z before load", {29'd0, zv}, 32'd7);
    load(8'h78, 1'b1, 2'd0);
    chk("collide z after load", {29'd0, zv}, 32'd0);
    repeat (5) begin
      send(2'd1, 3'b000); send(2'd3, 3'b000); send(2'd2, 3'b000); send(2'd0, 3'b111);
    end
    endchk("collide_sat", 3'b101);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
